spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Consumes the byte stream delivered by the SPI slave receiver's 8-deep byte FIFO (rdata/rstrb/dr).
- Parses framed host commands and issues 32-bit memory writes on the SoC native memory bus (valid/ready, wstrb).
- Also issues a boot-address handoff to the CPU reset/boot logic.
- Sits between the SPI slave receiver and the memory arbiter; used for host-side program loading.

Parameters:
- OPC_WRITE, 8'hA5, opcode for the block-write command.
- OPC_BOOT, 8'hC3, opcode for the boot-address command.
- TIMEOUT, 1000000, clk cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- rx_data  in  8  byte at head of receiver FIFO; valid while rx_dr=1
- rx_dr  in  1  receiver FIFO non-empty
- rx_strb  out  1  pop strobe to receiver; combinational
- mem_valid  out  1  write request
- mem_ready  in  1  write accepted
- mem_addr  out  32  word address, byte-addressed, bits [1:0]=0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte enables; 4'hF during a write, 0 otherwise
- boot_valid  out  1  one-cycle pulse with new boot address
- boot_addr  out  32  boot address; holds value until next boot command
- busy  out  1  1 whenever state != IDLE
- err  out  1  one-cycle pulse on bad opcode or timeout

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk.
- Reset values: state=IDLE; all outputs 0, including mem_addr, mem_wdata, boot_addr, rx_strb, boot_valid and err.
- Reset mid-frame or mid-write drops the frame and deasserts mem_valid at once. Any partial transfer is lost.
- Byte handshake:
  - rx_strb = rx_dr && (state in IDLE, ADDR, LEN, DATA).
  - A byte is consumed in the cycle rx_strb=1; rx_data is sampled on that edge.
  - Back-to-back strobes on consecutive cycles are legal.
  - rx_strb is never asserted in WRITE.
- Frame formats:
  - Write: OPC_WRITE, A3 A2 A1 A0 (address MSB first), N, then 4 data bytes per word, LSB first. N=0 means 256 words.
  - Boot: OPC_BOOT, A3 A2 A1 A0.
- States:
  - IDLE: consume one byte.
    - OPC_WRITE -> ADDR with kind=write.
    - OPC_BOOT -> ADDR with kind=boot.
    - Any other byte: pulse err, stay in IDLE. This provides resync.
  - ADDR: shift in 4 bytes, MSB first.
    - kind=write -> LEN.
    - kind=boot: boot_addr<=value, pulse boot_valid on the cycle after the 4th byte, -> IDLE.
  - LEN: latch the word count (9-bit, 0 maps to 256); byte index=0; -> DATA.
  - DATA: byte k goes to mem_wdata[8k+7:8k]. After the 4th byte -> WRITE, with mem_valid=1 and mem_wstrb=4'hF on the next cycle.
  - WRITE: hold mem_valid, mem_addr, mem_wdata and mem_wstrb stable until mem_ready=1.
    - On the accept edge: mem_valid<=0, mem_wstrb<=0, mem_addr<=mem_addr+4, remaining-word count decrements.
    - Count reaches 0 -> IDLE; otherwise -> DATA.
- mem_addr bits [1:0] are forced to 0 when loaded. Address increment wraps modulo 2^32 (32'hFFFFFFFC+4 = 0).
- mem_ready while mem_valid=0 is ignored.
- Timeout:
  - The counter runs in ADDR, LEN and DATA whenever no byte is consumed, and clears on every consumed byte and on state entry.
  - Reaching TIMEOUT -> IDLE with an err pulse; any partial word is discarded.
  - WRITE is not timed (bus stall is legal).
- Simultaneous events: reset has priority over everything, then timeout, then byte consumption.

Decomposition:
- Shared package spi_cmd_pkg holds:
  - opcode constants OPC_WRITE and OPC_BOOT;
  - a state enum {IDLE, ADDR, LEN, DATA, WRITE};
  - command-kind constants.
- One natural sub-module, spi_cmd_timer: a loadable/clearable down-counter of width $clog2(TIMEOUT+1) that outputs expired.

Test Plan:
- Bytes A5 00 00 10 00 02 11 22 33 44 55 66 77 88 with mem_ready=1 -> two writes: addr 0x00001000 wdata 0x44332211, then addr 0x00001004 wdata 0x88776655; wstrb=F; busy falls after the 2nd accept.
- Bytes C3 40 00 00 00 -> boot_addr=0x40000000, one-cycle boot_valid; no mem_valid asserted.
- Bytes 7E then a valid 1-word write frame -> one err pulse, then the write completes normally.
- Write frame with mem_ready held low for 50 cycles while 4 more bytes are queued -> mem_valid and all fields stable for 50 cycles, rx_strb=0 throughout, and next word issued after accept.
- Address FF FF FF FC, N=2 -> writes at 0xFFFFFFFC then 0x00000000.
- Frame stalls after 2 data bytes (TIMEOUT set to 100) -> err pulse at cycle 100 and back to IDLE. resetn=0 mid-WRITE -> mem_valid=0 on the next edge.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM states, command kinds.
package spi_cmd_pkg;

    localparam logic [7:0] OPC_WRITE = 8'hA5;
    localparam logic [7:0] OPC_BOOT  = 8'hC3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        WRITE
    } state_t;

    localparam logic KIND_WRITE = 1'b0;
    localparam logic KIND_BOOT  = 1'b1;

endpackage

// File: rtl/spi_cmd_timer.sv
// Inter-byte timeout counter: reloads to TIMEOUT, counts down while running,
// and flags expiry on the TIMEOUT-th consecutive running cycle.
module spi_cmd_timer #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // Reload on reset or load, otherwise count down while running
    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            count <= W'(TIMEOUT);
        end else if (run && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = run && !load && (count == W'(1));

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses framed host commands from the SPI receiver FIFO into 32-bit memory
// writes and boot-address handoffs.
module spi_cmd_decoder #(
    parameter logic [7:0]  OPC_WRITE = spi_cmd_pkg::OPC_WRITE,
    parameter logic [7:0]  OPC_BOOT  = spi_cmd_pkg::OPC_BOOT,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_dr,
    output logic        rx_strb,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        boot_valid,
    output logic [31:0] boot_addr,
    output logic        busy,
    output logic        err
);

    import spi_cmd_pkg::*;

    state_t      state;
    logic        kind;
    logic [1:0]  idx;
    logic [8:0]  words;
    logic [23:0] shift;
    logic [31:0] addr_word;
    logic        timer_run;
    logic        expired;

    assign rx_strb   = resetn && rx_dr && (state inside {IDLE, ADDR, LEN, DATA});
    assign busy      = (state != IDLE);
    assign addr_word = {shift, rx_data};
    assign timer_run = (state inside {ADDR, LEN, DATA}) && !rx_strb;

    spi_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .load    (!timer_run),
        .run     (timer_run),
        .expired (expired)
    );

    // Frame parser and bus-write sequencer; timeout overrides byte handling
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            kind       <= KIND_WRITE;
            idx        <= '0;
            words      <= '0;
            shift      <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            boot_valid <= 1'b0;
            boot_addr  <= '0;
            err        <= 1'b0;
        end else begin
            boot_valid <= 1'b0;
            err        <= 1'b0;
            if (expired) begin
                state <= IDLE;
                err   <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (rx_strb) begin
                        idx <= '0;
                        if (rx_data == OPC_WRITE) begin
                            kind  <= KIND_WRITE;
                            state <= ADDR;
                        end else if (rx_data == OPC_BOOT) begin
                            kind  <= KIND_BOOT;
                            state <= ADDR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    ADDR: if (rx_strb) begin
                        shift <= addr_word[23:0];
                        idx   <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            if (kind == KIND_BOOT) begin
                                boot_addr  <= addr_word;
                                boot_valid <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                mem_addr <= {addr_word[31:2], 2'b00};
                                state    <= LEN;
                            end
                        end
                    end
                    LEN: if (rx_strb) begin
                        words <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        idx   <= '0;
                        state <= DATA;
                    end
                    DATA: if (rx_strb) begin
                        mem_wdata[{idx, 3'b000} +: 8] <= rx_data;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            mem_valid <= 1'b1;
                            mem_wstrb <= 4'hF;
                            state     <= WRITE;
                        end
                    end
                    WRITE: if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= '0;
                        mem_addr  <= mem_addr + 32'd4;
                        words     <= words - 9'd1;
                        idx       <= '0;
                        state     <= (words == 9'd1) ? IDLE : DATA;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder (TIMEOUT reduced to 100).
module tb_spi_cmd_decoder;

    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_dr;
    logic        rx_strb;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        boot_valid;
    logic [31:0] boot_addr;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    logic [7:0] rxq[$];
    wr_t        wrq[$];
    int         err_cnt, boot_cnt, valid_cnt;
    logic       take = 1'b0;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_data    (rx_data),
        .rx_dr      (rx_dr),
        .rx_strb    (rx_strb),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .boot_valid (boot_valid),
        .boot_addr  (boot_addr),
        .busy       (busy),
        .err        (err)
    );

    // Receiver FIFO model: pops on a strobed edge, presents the head byte after it
    initial begin
        rx_dr   = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (take && rxq.size() > 0) void'(rxq.pop_front());
            rx_dr   = (rxq.size() != 0);
            rx_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
            @(negedge clk);
            #4;
            take = rx_strb;
        end
    end

    // Observer: records accepted writes and counts pulse cycles
    initial begin
        err_cnt = 0; boot_cnt = 0; valid_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (mem_valid === 1'b1 && mem_ready === 1'b1)
                wrq.push_back('{a: mem_addr, d: mem_wdata, s: mem_wstrb});
            if (err === 1'b1)        err_cnt++;
            if (boot_valid === 1'b1) boot_cnt++;
            if (mem_valid === 1'b1)  valid_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        tick(1);
        err_cnt = 0; boot_cnt = 0; valid_cnt = 0;
        wrq.delete();
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        int n = 0;
        tick(2);
        while ((rxq.size() != 0 || rx_dr || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tick(3);
        ok = (n < budget);
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        int n = 0;
        while (mem_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (mem_valid === 1'b1);
    endtask

    function automatic wr_t get_wr(input int i);
        wr_t w;
        w.a = 'x; w.d = 'x; w.s = 'x;
        if (i < wrq.size()) w = wrq[i];
        return w;
    endfunction

    task automatic test_reset();
        resetn    = 1'b0;
        mem_ready = 1'b1;
        rxq.push_back(8'h7E);
        tick(3);
        total++;
        if (rx_strb !== 1'b0) begin
            bad++; $display("FAIL reset_strb: rx_strb=%b want 0 (rx_dr=%b)", rx_strb, rx_dr);
        end
        total++;
        if ({mem_valid, mem_wstrb, boot_valid, busy, err} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl: valid=%b wstrb=%h boot_valid=%b busy=%b err=%b want all 0",
                            mem_valid, mem_wstrb, boot_valid, busy, err);
        end
        total++;
        if ({mem_addr, mem_wdata, boot_addr} !== 96'h0) begin
            bad++; $display("FAIL reset_data: addr=%h wdata=%h boot_addr=%h want 0", mem_addr, mem_wdata, boot_addr);
        end
        rxq.delete();
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    task automatic test_write_two();
        logic [7:0] f[14] = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02,
                              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic ok;
        wr_t w;
        clear_obs();
        foreach (f[i]) rxq.push_back(f[i]);
        wait_idle(200, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL write2_idle: decoder still busy, want idle"); end
        total++;
        if (wrq.size() != 2) begin bad++; $display("FAIL write2_count: got %0d writes want 2", wrq.size()); end
        w = get_wr(0);
        total++;
        if ({w.a, w.d, w.s} !== {32'h0000_1000, 32'h4433_2211, 4'hF}) begin
            bad++; $display("FAIL write2_w0: got a=%h d=%h s=%h want a=00001000 d=44332211 s=f", w.a, w.d, w.s);
        end
        w = get_wr(1);
        total++;
        if ({w.a, w.d, w.s} !== {32'h0000_1004, 32'h8877_6655, 4'hF}) begin
            bad++; $display("FAIL write2_w1: got a=%h d=%h s=%h want a=00001004 d=88776655 s=f", w.a, w.d, w.s);
        end
        total++;
        if ({busy, mem_valid, mem_wstrb, err_cnt} !== {1'b0, 1'b0, 4'h0, 32'd0}) begin
            bad++; $display("FAIL write2_end: busy=%b valid=%b wstrb=%h errs=%0d want 0", busy, mem_valid, mem_wstrb, err_cnt);
        end
    endtask

    task automatic test_boot();
        logic [7:0] f[5] = '{8'hC3, 8'h40, 8'h00, 8'h00, 8'h00};
        logic ok;
        clear_obs();
        foreach (f[i]) rxq.push_back(f[i]);
        wait_idle(100, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL boot_idle: decoder still busy, want idle"); end
        total++;
        if (boot_addr !== 32'h4000_0000) begin
            bad++; $display("FAIL boot_addr: got %h want 40000000", boot_addr);
        end
        total++;
        if (boot_cnt != 1) begin bad++; $display("FAIL boot_pulse: boot_valid high %0d cycles want 1", boot_cnt); end
        total++;
        if (valid_cnt != 0) begin bad++; $display("FAIL boot_novalid: mem_valid high %0d cycles want 0", valid_cnt); end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] f[11] = '{8'h7E, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h03, 8'h01,
                              8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic ok;
        wr_t w;
        clear_obs();
        foreach (f[i]) rxq.push_back(f[i]);
        wait_idle(100, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL badop_idle: decoder still busy, want idle"); end
        total++;
        if (err_cnt != 1) begin bad++; $display("FAIL badop_err: err high %0d cycles want 1", err_cnt); end
        total++;
        if (wrq.size() != 1) begin bad++; $display("FAIL badop_count: got %0d writes want 1", wrq.size()); end
        w = get_wr(0);
        total++;
        if ({w.a, w.d, w.s} !== {32'h0000_0100, 32'hEFBE_ADDE, 4'hF}) begin
            bad++; $display("FAIL badop_w0: got a=%h d=%h s=%h want a=00000100 d=efbeadde s=f", w.a, w.d, w.s);
        end
    endtask

    task automatic test_stall();
        logic [7:0] f[14] = '{8'hA5, 8'h00, 8'h00, 8'h30, 8'h00, 8'h02,
                              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        logic ok;
        logic [67:0] snap;
        int unstable = 0;
        wr_t w;
        clear_obs();
        mem_ready = 1'b0;
        foreach (f[i]) rxq.push_back(f[i]);
        wait_valid(100, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL stall_valid: mem_valid=%b want 1", mem_valid); end
        snap = {mem_addr, mem_wdata, mem_wstrb};
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (mem_valid !== 1'b1 || rx_strb !== 1'b0 || {mem_addr, mem_wdata, mem_wstrb} !== snap)
                unstable++;
        end
        total++;
        if (unstable != 0) begin bad++; $display("FAIL stall_hold: %0d unstable cycles want 0", unstable); end
        total++;
        if (snap !== {32'h0000_3000, 32'h0403_0201, 4'hF}) begin
            bad++; $display("FAIL stall_fields: got %h want 00003000_04030201_f", snap);
        end
        total++;
        if (rxq.size() != 4 || err_cnt != 0) begin
            bad++; $display("FAIL stall_queue: queued=%0d errs=%0d want 4 and 0", rxq.size(), err_cnt);
        end
        mem_ready = 1'b1;
        wait_idle(100, ok);
        w = get_wr(1);
        total++;
        if (wrq.size() != 2 || {w.a, w.d} !== {32'h0000_3004, 32'h0807_0605}) begin
            bad++; $display("FAIL stall_next: writes=%0d a=%h d=%h want 2, 00003004, 08070605", wrq.size(), w.a, w.d);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] f[14] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h02,
                              8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        logic ok;
        wr_t w;
        clear_obs();
        foreach (f[i]) rxq.push_back(f[i]);
        wait_idle(200, ok);
        w = get_wr(0);
        total++;
        if ({w.a, w.d} !== {32'hFFFF_FFFC, 32'h4030_2010}) begin
            bad++; $display("FAIL wrap_w0: got a=%h d=%h want a=fffffffc d=40302010", w.a, w.d);
        end
        w = get_wr(1);
        total++;
        if ({w.a, w.d} !== {32'h0000_0000, 32'h8070_6050}) begin
            bad++; $display("FAIL wrap_w1: got a=%h d=%h want a=00000000 d=80706050", w.a, w.d);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] f[8] = '{8'hA5, 8'h00, 8'h00, 8'h50, 8'h00, 8'h01, 8'hAA, 8'hBB};
        int k = 0;
        int n = 0;
        clear_obs();
        foreach (f[i]) rxq.push_back(f[i]);
        while (rxq.size() != 0 && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        while (err !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != TMO + 1) begin
            bad++; $display("FAIL timeout_delay: err seen at cycle %0d want %0d", n, TMO + 1);
        end
        tick(4);
        total++;
        if (busy !== 1'b0 || err_cnt != 1 || wrq.size() != 0) begin
            bad++; $display("FAIL timeout_abort: busy=%b errs=%0d writes=%0d want 0, 1, 0", busy, err_cnt, wrq.size());
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] f[10] = '{8'hA5, 8'h00, 8'h00, 8'h60, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] g[10] = '{8'hA5, 8'h00, 8'h00, 8'h70, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic ok;
        wr_t w;
        clear_obs();
        mem_ready = 1'b0;
        foreach (f[i]) rxq.push_back(f[i]);
        wait_valid(100, ok);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({mem_valid, busy, mem_wstrb} !== 6'b0) begin
            bad++; $display("FAIL rst_write: valid=%b busy=%b wstrb=%h want 0", mem_valid, busy, mem_wstrb);
        end
        @(negedge clk);
        resetn    = 1'b1;
        mem_ready = 1'b1;
        tick(5);
        total++;
        if (wrq.size() != 0 || mem_valid !== 1'b0) begin
            bad++; $display("FAIL rst_drop: writes=%0d valid=%b want 0 and 0", wrq.size(), mem_valid);
        end
        foreach (g[i]) rxq.push_back(g[i]);
        wait_idle(100, ok);
        w = get_wr(0);
        total++;
        if (wrq.size() != 1 || {w.a, w.d} !== {32'h0000_7000, 32'hDDCC_BBAA}) begin
            bad++; $display("FAIL rst_recover: writes=%0d a=%h d=%h want 1, 00007000, ddccbbaa", wrq.size(), w.a, w.d);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_write_two();
        test_boot();
        test_bad_opcode();
        test_stall();
        test_wrap();
        test_timeout();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
